// File: rtl/sumador_serie_if.sv
// rtl/sumador_serie_if.sv - start/busy/done operand and result bundle for the bit-serial adder
interface sumador_serie_if #(
  parameter int WIDTH = 8
);
  // request side: captured by the adder on the accepting edge
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  // response side: sum/cout/overflow move only on completion
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/sumador_serie.sv
// rtl/sumador_serie.sv - bit-serial adder/subtractor, one full-adder cell and a carry flop, LSB first
module sumador_serie #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  sumador_serie_if.slave bus
);

  // one counter bit minimum so WIDTH=1 still has a legal vector
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // the single full-adder cell fed by the operand LSBs and the carry flop
  logic             fa_s;
  logic             fa_c;
  // new bit enters at the MSB end; the concat keeps the slice legal when WIDTH=1
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;

  assign fa_s     = sa_q[0] ^ sb_q[0] ^ c_q;
  assign fa_c     = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign res_cat  = {fa_s, res_q};
  assign res_next = res_cat[WIDTH:1];

  // state and datapath registers; reset clears everything so outputs read zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // next-state: load operands on accept, then one bit per edge until the MSB is done
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // subtract is a + ~b + ~borrow, so invert B and the incoming carry here
          sa_d    = bus.a;
          sb_d    = bus.mode ? ~bus.b : bus.b;
          c_d     = bus.mode ? ~bus.cin : bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_next;
        c_d   = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // c_q is the carry into the MSB, fa_c the carry out of it
          sum_d   = res_next;
          cout_d  = fa_c;
          ovf_d   = c_q ^ fa_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/sumador_serie.md
# sumador_serie

Parametrised bit-serial adder/subtractor: the multi-bit successor of the team's 1-bit full-adder tile. Uses a single full-adder cell plus a carry flip-flop to add or subtract two WIDTH-bit operands one bit per clock, LSB first. Operands, control and results use a start/busy/done handshake. The block sits behind the Tiny Tapeout top wrapper, which maps its ports onto ui_in/uio_in/uo_out.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..32.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only on an edge where busy=0.
- mode  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  add: carry-in; subtract: borrow-in. Sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- sum  output  WIDTH  result, registered, held until the next completion.
- cout  output  1  raw carry out of the MSB (subtract: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow of the last result.

## Operation
- States:
  - IDLE (busy=0).
  - SHIFT (busy=1).
- Reset forces IDLE and clears every register. Outputs read busy=0, done=0, sum=0, cout=0, overflow=0.
- IDLE, start=1 at an edge:
  - Latch a into shift register SA and b into SB. In subtract, SB is loaded with ~b.
  - Load carry FF with cin (add) or ~cin (subtract).
  - Clear bit counter; enter SHIFT.
- SHIFT, each edge:
  - s = SA[0]^SB[0]^c, c_next = majority(SA[0],SB[0],c).
  - s shifts into a result shift register from the MSB end; SA and SB shift right; the counter increments.
- Counter reaches WIDTH-1:
  - That edge processes the MSB.
  - Load sum from the result register including the final bit.
  - cout = c_next; overflow = c (the carry into the MSB) XOR c_next.
  - Pulse done; return to IDLE.
- Arithmetic:
  - add: sum = (a+b+cin) mod 2^WIDTH.
  - subtract: sum = (a-b-cin) mod 2^WIDTH, implemented as a+~b+~cin.
- start while busy=1 is ignored. No queuing and no error flag.
- mode, a, b and cin may change freely after acceptance; the latched copies are used.
- sum, cout and overflow change only at completion. They are otherwise stable, including while a new operation runs.
- WIDTH=1: a single SHIFT cycle; the block behaves as a registered full adder.
- Counter width: max(1, clog2(WIDTH)).

## Timing
- start accepted at edge k: busy=1 after edge k.
- Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
- After edge k+WIDTH:
  - busy=0, done=1 for exactly one cycle.
  - sum, cout and overflow are valid.
- Latency start→done: WIDTH+1 edges. Throughput: one operation per WIDTH+1 cycles.
- start=1 in the done cycle is accepted (busy=0 then), giving back-to-back operation.
- rst_n=0 mid-operation:
  - Next edge: IDLE with all outputs zero.
  - The partial result is discarded and done never fires.
- rst_n=0 and start=1 on the same edge: reset wins.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 → done 9 edges after start; sum=0x96, cout=0, overflow=1.
- WIDTH=8, add, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Repeat with cin=1 → sum=0x01, cout=1.
- WIDTH=8, subtract:
  - a=0x10, b=0x20, cin=0 → sum=0xF0, cout=0, overflow=0.
  - a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.
- Start 0x01+0x01; pulse start with 0xFF+0xFF at edge k+3 → that start is ignored. Done at k+9 with sum=0x02. Then start in the done cycle with 0x03+0x04 → sum=0x07 nine edges later.
- Reset mid-operation: start 0xAA+0x55, drop rst_n at edge k+4 → next edge busy=0, sum=0, done never asserts. A fresh start then completes normally.
- WIDTH=1 and WIDTH=32 builds, all 8 add/cin combinations (WIDTH=1) and 0xFFFFFFFF+1 (WIDTH=32):
  - WIDTH=1: done after 2 edges; sum/cout match the full-adder truth table.
  - WIDTH=32: sum=0, cout=1, done after 33 edges.
